// File: rtl/serial_nibble_rx.sv
// serial_nibble_rx: UART-style serial receiver producing 4-bit words.
// The rx line passes through a SYNC_STAGES synchronizer. Each frame has a start
// bit, 4 data bits (LSB first) and a stop bit. Sampling happens at mid-bit.
// A good frame updates data_out and pulses data_valid for one cycle.
// A low stop bit pulses frame_err; the receiver then waits for the line to go high.
// Optional macro RX_PARITY_EN inserts one even-parity bit between the data and the stop bit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | half-bit wait, then confirm the start bit (reject glitches)
// DATA      | sample 4 data bits, one per bit period
// PARITY    | sample the even-parity bit (RX_PARITY_EN only)
// STOP      | sample the stop bit, then publish the word or flag an error
// WAIT_HIGH | bad stop seen; hold off until the line returns high
module serial_nibble_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef RX_PARITY_EN
        PARITY    = 3'd5,
`endif
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t        state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [1:0]    bit_idx_q;
    logic [3:0]    shift_q;
    logic [3:0]    data_out_q;
    logic          data_valid_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          cnt_tc;

    // Synchronizer chain. Reset loads ones so the line looks idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign cnt_tc = (clk_cnt_q == '0);

`ifdef RX_PARITY_EN
    logic parity_bad_q;
    logic parity_err_q;
`endif

    // Receive FSM with down-counter bit timing and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= 2'd0;
            shift_q      <= 4'd0;
            data_out_q   <= 4'd0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q   <= START;
                        clk_cnt_q <= HALF_LOAD;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_tc) begin
                        if (rx_s) begin
                            // Start bit vanished by mid-bit: it was a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= 2'd0;
                            clk_cnt_q <= FULL_LOAD;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_tc) begin
                        shift_q[bit_idx_q] <= rx_s;
                        clk_cnt_q          <= FULL_LOAD;
                        if (bit_idx_q == 2'd3) begin
`ifdef RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 2'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (cnt_tc) begin
                        // Even parity: data bits plus parity bit must have an even count of ones.
                        parity_bad_q <= rx_s ^ (^shift_q);
                        clk_cnt_q    <= FULL_LOAD;
                        state_q      <= STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_tc) begin
                        if (rx_s) begin
                            // Go to IDLE mid-stop-bit so a start bit right after the stop is not missed.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`ifdef RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_out_q   <= shift_q;
                                data_valid_q <= 1'b1;
                            end
`else
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Testbench for serial_nibble_rx. Each stimulus segment is a per-cycle waveform on rx.
// A frame-level reference model turns each segment into expected per-cycle outputs.
// The outputs are compared every cycle. Honours RX_PARITY_EN when defined.
module tb_serial_nibble_rx;
    localparam int C = 4;
    localparam int S = 2;
`ifdef RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] data_out;
    logic       data_valid, frame_err, parity_err, busy;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] model_dout = 4'd0;
    bit         wave[$];
    logic [7:0] exp_v[];
    int         dv_at[$];

    serial_nibble_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
        .data_valid(data_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_bits(bit b, int n);
        repeat (n) wave.push_back(b);
    endtask

    function automatic bit even_par(logic [3:0] d);
        return ^d;
    endfunction

    task automatic add_frame(logic [3:0] d, bit par, bit stop);
        add_bits(1'b0, C);
        for (int i = 0; i < 4; i++) add_bits(d[i], C);
        if (PAR != 0) add_bits(par, C);
        add_bits(stop, C);
    endtask

    // Synchronized line value the receiver sees in cycle t.
    function automatic bit rxs(int t);
        if (t < S) return 1'b1;
        return wave[t-S];
    endfunction

    // Frame-level reference. T0 is the first idle cycle with the synchronized line low.
    // Samples fall at T0+C/2+k*C. Result pulses appear one cycle after the stop sample.
    task automatic build_model(int n);
        bit bz[], dv[], fe[], pe[];
        logic [3:0] dd[];
        logic [3:0] dout, d;
        int t, t0, p, s, h;
        bz = new[n]; dv = new[n]; fe = new[n]; pe = new[n]; dd = new[n];
        t = 0;
        while (t < n) begin
            if (rxs(t)) begin
                t++;
                continue;
            end
            t0 = t;
            p  = t0 + C / 2;
            s  = p + (5 + PAR) * C;
            if (s + 1 >= n) break;
            for (int u = t0 + 1; u <= p; u++) bz[u] = 1'b1;
            if (rxs(p)) begin
                t = p + 1;
                continue;
            end
            for (int i = 0; i < 4; i++) d[i] = rxs(p + (i + 1) * C);
            for (int u = p; u <= s; u++) bz[u] = 1'b1;
            if (!rxs(s)) begin
                fe[s+1] = 1'b1;
                h = s + 1;
                while (h < n && !rxs(h)) begin
                    bz[h] = 1'b1;
                    h++;
                end
                if (h < n) bz[h] = 1'b1;
                t = h + 1;
            end else if (PAR != 0 && ((^d) != rxs(p + 5 * C))) begin
                pe[s+1] = 1'b1;
                t = s + 1;
            end else begin
                dv[s+1] = 1'b1;
                dd[s+1] = d;
                t = s + 1;
            end
        end
        exp_v = new[n];
        dout  = model_dout;
        for (int u = 0; u < n; u++) begin
            if (dv[u]) dout = dd[u];
            exp_v[u] = {bz[u], dv[u], fe[u], pe[u], dout};
        end
        model_dout = dout;
    endtask

    // Drive the queued waveform one value per cycle and compare the outputs every cycle.
    task automatic run_segment(string tag);
        int n;
        n = wave.size() + S + (6 + PAR) * C + 4;
        while (wave.size() < n) wave.push_back(1'b1);
        build_model(n);
        dv_at.delete();
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            rx = wave[t];
            if (data_valid === 1'b1) dv_at.push_back(t);
            check(tag, {24'd0, busy, data_valid, frame_err, parity_err, data_out}, {24'd0, exp_v[t]});
        end
        wave.delete();
    endtask

    initial begin
        int kind, g;
        logic [3:0] d;
        bit p, st;

        // Reset state
        #2 reset = 1'b1;
        #1 check("reset_state", {busy, data_valid, frame_err, parity_err, data_out}, 8'h00);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // Idle line: no pulses
        add_bits(1'b1, 50);
        run_segment("idle50");

        // Frame 4'hD and its latency
        add_bits(1'b1, 3);
        add_frame(4'hD, even_par(4'hD), 1'b1);
        run_segment("frame_d");
        check("lat_d_cnt", dv_at.size(), 1);
        if (dv_at.size() > 0) check("lat_d", dv_at[0], 3 + S + C / 2 + (5 + PAR) * C + 1);
        check("hold_d", data_out, 4'hD);

        // Back-to-back frames with no idle gap
        add_frame(4'h3, even_par(4'h3), 1'b1);
        add_frame(4'hA, even_par(4'hA), 1'b1);
        run_segment("b2b");
        check("b2b_cnt", dv_at.size(), 2);
        if (dv_at.size() == 2) check("b2b_gap", dv_at[1] - dv_at[0], (6 + PAR) * C);

        // Short low glitches
        add_bits(1'b1, 2); add_bits(1'b0, 1); add_bits(1'b1, 10);
        add_bits(1'b0, C / 2); add_bits(1'b1, 10);
        run_segment("glitch");
        check("glitch_hold", data_out, 4'hA);

        // Bad stop, line held low, then a good frame
        add_frame(4'h5, even_par(4'h5), 1'b0);
        add_bits(1'b0, 30); add_bits(1'b1, C);
        add_frame(4'h6, even_par(4'h6), 1'b1);
        run_segment("break");
        check("break_data", data_out, 4'h6);

`ifdef RX_PARITY_EN
        // Parity mismatch with good stop, then mismatch with bad stop
        add_frame(4'h7, ~even_par(4'h7), 1'b1);
        add_bits(1'b1, C);
        add_frame(4'h7, ~even_par(4'h7), 1'b0);
        add_bits(1'b1, C);
        run_segment("parity");
        check("parity_hold", data_out, 4'h6);
`endif

        // Reset asserted in the middle of the data bits
        add_frame(4'h9, even_par(4'h9), 1'b1);
        for (int t = 0; t < S + C / 2 + 2 * C; t++) begin
            @(posedge clk);
            #1 rx = wave[t];
        end
        #2 reset = 1'b1;
        #1 check("rst_mid", {busy, data_valid, frame_err, parity_err, data_out}, 8'h00);
        @(posedge clk);
        #1 rx = 1'b1;
        check("rst_held", {busy, data_valid, frame_err, parity_err, data_out}, 8'h00);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        wave.delete();
        model_dout = 4'd0;
        add_bits(1'b1, 4);
        add_frame(4'hB, even_par(4'hB), 1'b1);
        run_segment("post_rst");

        // Randomized traffic: frames, glitches, bad stops, parity errors, gaps
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 9);
            d    = 4'($urandom_range(0, 15));
            p    = ($urandom_range(0, 4) == 0) ? ~even_par(d) : even_par(d);
            st   = ($urandom_range(0, 5) != 0);
            if (kind == 0) begin
                add_bits(1'b0, $urandom_range(1, C / 2));
                add_bits(1'b1, $urandom_range(C, 2 * C));
            end else begin
                add_frame(d, p, st);
                if (!st) begin
                    add_bits(1'b0, $urandom_range(0, 10));
                    add_bits(1'b1, C);
                end
            end
            g = $urandom_range(0, 3);
            if (g != 0) add_bits(1'b1, $urandom_range(0, 5));
        end
        run_segment("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
